// File: rtl/pong_gfx_pkg.sv
// Shared graphics definitions for the pong datapath: screen geometry, palette,
// rectangle command format and the plotter state encoding.
package pong_gfx_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int XW       = 8;
    localparam int YW       = 7;
    localparam int CW       = 3;

    localparam logic [CW-1:0] COL_BLACK = 3'b000;
    localparam logic [CW-1:0] COL_BG    = 3'b101;
    localparam logic [CW-1:0] COL_BLUE  = 3'b001;
    localparam logic [CW-1:0] COL_RED   = 3'b100;
    localparam logic [CW-1:0] COL_GREEN = 3'b010;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } plot_state_e;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        logic [CW-1:0] colour;
    } rect_cmd_t;

    localparam int CMD_W = $bits(rect_cmd_t);

endpackage

// File: rtl/rect_cmd_fifo.sv
// 4-entry synchronous command queue feeding rect_plotter; only built when
// RECT_PLOTTER_CMD_FIFO_EN is defined.
`ifdef RECT_PLOTTER_CMD_FIFO_EN
module rect_cmd_fifo
    import pong_gfx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [CMD_W-1:0] cmd_i,
    input  logic             pop_i,
    output logic [CMD_W-1:0] cmd_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 4;

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == 3'(DEPTH));
    assign empty_o = (count_q == 3'd0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign cmd_o   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + 2'(push_ok);
        rd_ptr_d = rd_ptr_q + 2'(pop_ok);
        count_d  = count_q + 3'(push_ok) - 3'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is left unreset; count_q gates every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= cmd_i;
        end
    end

endmodule
`endif

// File: rtl/rect_plotter.sv
// Rectangle-fill engine: one clipped pixel write per cycle, row-major.
// Define RECT_PLOTTER_CMD_FIFO_EN to queue commands and stream them gap-free.
module rect_plotter
    import pong_gfx_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_y,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [CW-1:0] cmd_colour,
    output logic [XW-1:0] plot_x,
    output logic [YW-1:0] plot_y,
    output logic [CW-1:0] plot_colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam logic [XW:0] X_LIM = (XW+1)'(SCREEN_W);
    localparam logic [YW:0] Y_LIM = (YW+1)'(SCREEN_H);

    plot_state_e   state_q, state_d;
    logic [XW-1:0] x_q, x_d, x_start_q, x_start_d, x_last_q, x_last_d;
    logic [YW-1:0] y_q, y_d, y_last_q, y_last_d;
    logic [CW-1:0] colour_q, colour_d;
    logic          plot_q, plot_d, done_q, done_d;

    rect_cmd_t     in_cmd, src_cmd;
    logic          load, last_px, degenerate;
    logic [XW:0]   x_sum, x_end;
    logic [YW:0]   y_sum, y_end;
    logic [XW-1:0] x_last_w;
    logic [YW-1:0] y_last_w;

    assign in_cmd  = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour};
    assign last_px = (state_q == ST_FILL) && done_q;

`ifdef RECT_PLOTTER_CMD_FIFO_EN
    logic fifo_full, fifo_empty;

    rect_cmd_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid && cmd_ready),
        .cmd_i   (in_cmd),
        .pop_i   (load),
        .cmd_o   (src_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Popping on the last-pixel cycle lets the next command start with no gap.
    assign cmd_ready = rst && !fifo_full;
    assign load      = rst && !fifo_empty && ((state_q == ST_IDLE) || last_px);
    assign busy      = !fifo_empty || (state_q == ST_FILL);
`else
    assign src_cmd   = in_cmd;
    assign cmd_ready = rst && (state_q == ST_IDLE);
    assign load      = cmd_valid && cmd_ready;
    assign busy      = (state_q == ST_FILL);
`endif

    // Sums are one bit wider than the operands so large commands clip instead of wrapping.
    assign x_sum      = {1'b0, src_cmd.x} + {1'b0, src_cmd.w};
    assign y_sum      = {1'b0, src_cmd.y} + {1'b0, src_cmd.h};
    assign x_end      = (x_sum > X_LIM) ? X_LIM : x_sum;
    assign y_end      = (y_sum > Y_LIM) ? Y_LIM : y_sum;
    assign x_last_w   = XW'(x_end - 1'b1);
    assign y_last_w   = YW'(y_end - 1'b1);
    assign degenerate = (src_cmd.w == '0) || (src_cmd.h == '0) ||
                        ({1'b0, src_cmd.x} >= X_LIM) || ({1'b0, src_cmd.y} >= Y_LIM);

    always_comb begin
        // NOTE: every _d is defaulted first so no path through this block infers a latch.
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        x_start_d = x_start_q;
        x_last_d  = x_last_q;
        y_last_d  = y_last_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
        done_d    = 1'b0;

        if ((state_q == ST_FILL) && !done_q) begin
            plot_d = 1'b1;
            if (x_q == x_last_q) begin
                x_d = x_start_q;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            done_d = (x_d == x_last_q) && (y_d == y_last_q);
        end else if (last_px) begin
            state_d = ST_IDLE;
        end

        if (load) begin
            if (degenerate) begin
                state_d = ST_IDLE;
                plot_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d   = ST_FILL;
                x_d       = src_cmd.x;
                y_d       = src_cmd.y;
                x_start_d = src_cmd.x;
                x_last_d  = x_last_w;
                y_last_d  = y_last_w;
                colour_d  = src_cmd.colour;
                plot_d    = 1'b1;
                done_d    = (src_cmd.x == x_last_w) && (src_cmd.y == y_last_w);
            end
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            x_start_q <= '0;
            x_last_q  <= '0;
            y_last_q  <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            x_start_q <= x_start_d;
            x_last_q  <= x_last_d;
            y_last_q  <= y_last_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            done_q    <= done_d;
        end
    end

    assign plot_x      = x_q;
    assign plot_y      = y_q;
    assign plot_colour = colour_q;
    assign plot        = plot_q;
    assign done        = done_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Directed self-checking bench for rect_plotter (default build, plus a queued
// streaming scenario when RECT_PLOTTER_CMD_FIFO_EN is defined).
module tb_rect_plotter;
    import pong_gfx_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [XW-1:0] cmd_x;
    logic [YW-1:0] cmd_y;
    logic [XW-1:0] cmd_w;
    logic [YW-1:0] cmd_h;
    logic [CW-1:0] cmd_colour;
    logic [XW-1:0] plot_x;
    logic [YW-1:0] plot_y;
    logic [CW-1:0] plot_colour;
    logic          plot;
    logic          busy;
    logic          done;

    int n_cmp  = 0;
    int n_fail = 0;

    rect_plotter dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_colour  (cmd_colour),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input int w, input int h, input logic [CW-1:0] c);
        cmd_x      = XW'(x);
        cmd_y      = YW'(y);
        cmd_w      = XW'(w);
        cmd_h      = YW'(h);
        cmd_colour = c;
        cmd_valid  = 1'b1;
    endtask

    // Presents a command in IDLE and returns on the cycle after acceptance.
    task automatic send(input int x, input int y, input int w, input int h, input logic [CW-1:0] c);
        drive(x, y, w, h, c);
        check("send_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic check_px(input string tag, input int ex, input int ey, input logic last);
        check(tag, {plot, done, plot_x, plot_y}, {1'b1, last, XW'(ex), YW'(ey)});
    endtask

    initial begin
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_x      = '0;
        cmd_y      = '0;
        cmd_w      = '0;
        cmd_h      = '0;
        cmd_colour = '0;
        tick();
        tick();

        check("rst_plot",   plot, 1'b0);
        check("rst_xy",     {plot_x, plot_y}, 15'd0);
        check("rst_colour", plot_colour, 3'd0);
        check("rst_busy",   busy, 1'b0);
        check("rst_done",   done, 1'b0);
        check("rst_ready",  cmd_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("idle_ready", cmd_ready, 1'b1);

`ifdef RECT_PLOTTER_CMD_FIFO_EN
        // Long 8x1 command occupies the engine while four 1x1 commands queue up.
        for (int cyc = 0; cyc <= 14; cyc++) begin
            if (cyc == 0)      drive(50, 50, 8, 1, COL_RED);
            else if (cyc <= 4) drive(70 + cyc - 1, 10, 1, 1, COL_BLUE);
            else if (cyc == 5) drive(99, 10, 1, 1, COL_GREEN);
            else               cmd_valid = 1'b0;

            if (cyc <= 4)       check("fifo_ready", cmd_ready, 1'b1);
            else if (cyc == 5)  check("fifo_full_ready", cmd_ready, 1'b0);

            if (cyc >= 2 && cyc <= 9) begin
                check_px("fifo_long_px", 50 + cyc - 2, 50, cyc == 9);
            end else if (cyc >= 10 && cyc <= 13) begin
                check_px("fifo_unit_px", 70 + cyc - 10, 10, 1'b1);
                check("fifo_unit_colour", plot_colour, COL_BLUE);
                check("fifo_busy", busy, 1'b1);
            end else begin
                check("fifo_no_plot", plot, 1'b0);
            end
            if (cyc == 14) check("fifo_end_busy", busy, 1'b0);
            tick();
        end
`else
        // Single column, 16 rows.
        send(10, 52, 1, 16, COL_BLUE);
        for (int i = 0; i < 16; i++) begin
            check_px("col_px", 10, 52 + i, i == 15);
            check("col_colour", plot_colour, COL_BLUE);
            check("col_busy", busy, 1'b1);
            check("col_ready", cmd_ready, 1'b0);
            tick();
        end
        check("col_after_plot", plot, 1'b0);
        check("col_after_done", done, 1'b0);
        check("col_after_busy", busy, 1'b0);
        check("col_hold_xy", {plot_x, plot_y}, {8'd10, 7'd67});
        check("col_after_ready", cmd_ready, 1'b1);

        // Full screen in raster order.
        send(0, 0, 160, 120, COL_BG);
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                check_px("full_px", x, y, (x == 159) && (y == 119));
                tick();
            end
        end
        check("full_after_plot", plot, 1'b0);

        // Bottom-right corner clipping.
        send(158, 118, 5, 5, COL_RED);
        for (int i = 0; i < 4; i++) begin
            check_px("clip_px", 158 + (i % 2), 118 + (i / 2), i == 3);
            check("clip_colour", plot_colour, COL_RED);
            tick();
        end
        check("clip_after_plot", plot, 1'b0);

        // Degenerate commands: zero width, off-screen x, off-screen y.
        send(20, 20, 0, 5, COL_GREEN);
        check("deg_w_plot",   plot, 1'b0);
        check("deg_w_done",   done, 1'b1);
        check("deg_w_ready",  cmd_ready, 1'b1);
        check("deg_w_busy",   busy, 1'b0);
        check("deg_w_colour", plot_colour, COL_RED);
        tick();
        check("deg_w_done_clr", done, 1'b0);
        send(160, 10, 4, 4, COL_GREEN);
        check("deg_x_plot",  plot, 1'b0);
        check("deg_x_done",  done, 1'b1);
        check("deg_x_ready", cmd_ready, 1'b1);
        tick();
        check("deg_x_done_clr", done, 1'b0);
        send(10, 120, 4, 4, COL_GREEN);
        check("deg_y_plot", plot, 1'b0);
        check("deg_y_done", done, 1'b1);
        tick();

        // Reset on the 5th pixel of a 4x4 fill.
        send(30, 40, 4, 4, COL_GREEN);
        for (int i = 0; i < 4; i++) tick();
        check_px("abort_5th_px", 30, 41, 1'b0);
        rst = 1'b0;
        tick();
        check("abort_plot",  plot, 1'b0);
        check("abort_done",  done, 1'b0);
        check("abort_ready", cmd_ready, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_quiet", {plot, done, busy}, 3'b000);
        end
        send(5, 6, 2, 1, COL_BLUE);
        check_px("post_abort_px0", 5, 6, 1'b0);
        tick();
        check_px("post_abort_px1", 6, 6, 1'b1);
        tick();
        check("post_abort_end", {plot, done, busy}, 3'b000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_plotter.md
Name: rect_plotter

Overview:
Rectangle-fill engine between the pong game FSM and the 160x120 VGA frame-buffer adapter. It accepts one rectangle command per valid/ready handshake and emits one pixel write per cycle on x/y/colour/plot, clipped to the screen. Background, centre line, paddle draw/erase and ball draw/erase become single commands, replacing per-state pixel counters in the game FSM.

Parameters:
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
XW, 8, x coordinate / width bits
YW, 7, y coordinate / height bits
CW, 3, colour bits (1 bit per RGB channel)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_x  in  XW  left column
cmd_y  in  YW  top row
cmd_w  in  XW  width in pixels
cmd_h  in  YW  height in pixels
cmd_colour  in  CW  fill colour
plot_x  out  XW  pixel column to adapter
plot_y  out  YW  pixel row to adapter
plot_colour  out  CW  pixel colour to adapter
plot  out  1  write strobe to adapter
busy  out  1  command in progress or queued
done  out  1  one-cycle pulse, command finished

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; plot=0, plot_x=0, plot_y=0, plot_colour=0, busy=0, done=0. cmd_ready=0 while rst=0.
- States: IDLE, FILL.
- IDLE: cmd_ready=1. On valid&ready, latch command; compute x_end=min(cmd_x+cmd_w, SCREEN_W), y_end=min(cmd_y+cmd_h, SCREEN_H) using XW+1 / YW+1 bit sums (no wrap).
- Degenerate command (w=0, h=0, cmd_x>=SCREEN_W or cmd_y>=SCREEN_H): no pixels; done=1 on the cycle after accept; stay IDLE.
- Otherwise go to FILL. First pixel (cmd_x,cmd_y) has plot=1 on the cycle after accept.
- FILL: one pixel per cycle, row-major; x increments to x_end-1, then wraps to cmd_x with y+1; ends after (x_end-1, y_end-1). Pixel count = clipped_w*clipped_h, with no gaps.
- done=1 in the same cycle as the last pixel's plot; next cycle returns to IDLE.
- Latency: accept -> first plot 1 cycle. Back-to-back commands: 1 idle cycle between the last pixel and the next accept (no FIFO).
- plot=0 whenever no pixel is emitted; plot_x/plot_y/plot_colour hold their last values then.
- busy=1 from the accept cycle+1 through the last-pixel cycle.
- Command inputs are ignored outside accept.
- Reset mid-FILL: abort immediately; no further plots, no done pulse.
- Full-screen command (0,0,160,120) gives 19200 pixels in 19200 consecutive cycles.

Optional Feature:
RECT_PLOTTER_CMD_FIFO_EN
- Defined: a 4-entry command FIFO sits in front of the engine; cmd_ready = !fifo_full (0 in reset). The engine pops on entering IDLE-with-nonempty or on the last-pixel cycle, so consecutive commands stream with zero gap cycles. busy=1 while the FIFO is non-empty or in FILL. Reset flushes the FIFO.
- Undefined: no FIFO; cmd_ready=1 only in IDLE as above.

Decomposition:
- Shared package pong_gfx_pkg:
  - SCREEN_W/SCREEN_H
  - colour constants COL_BLACK=3'b000, COL_BG=3'b101, COL_BLUE=3'b001, COL_RED=3'b100, COL_GREEN=3'b010
  - plotter state enum
  - packed rect_cmd struct (x, y, w, h, colour)
- Sub-module rect_cmd_fifo (4-deep, synchronous, rect_cmd-wide), instantiated only under RECT_PLOTTER_CMD_FIFO_EN.

Test Plan:
- Cmd (10,52,1,16,COL_BLUE) -> 16 plots at x=10, y=52..67 on consecutive cycles starting 1 cycle after accept; done with y=67; then IDLE.
- Cmd (0,0,160,120,COL_BG) -> exactly 19200 plots in raster order; last (159,119); done coincident.
- Clip: cmd (158,118,5,5) -> 4 plots (158,118),(159,118),(158,119),(159,119); no x>=160 or y>=120.
- Degenerate: w=0, then x=160 -> zero plots each; done 1 cycle after accept; cmd_ready back high.
- Reset asserted on the 5th pixel of a 4x4 fill -> plot=0 from the next cycle; no done; next command behaves normally.
- With RECT_PLOTTER_CMD_FIFO_EN: four 1x1 commands queued in 4 cycles -> 4 plots on 4 consecutive cycles, 4 done pulses, 5th command held off while full.
